wb_write_queue: RTL

//  Producer side of the register-file write port. Merges writeback requests from the
//  in-order pipeline (source A) and a long-latency unit (source B) into a DEPTH-entry
//  in-order queue. Drains the queue one entry per granted cycle onto reg_write/rd/write_data.

---
 rtl/wb_write_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_write_queue.sv
// Register-file writeback queue: merges pipeline (A) and long-latency (B) writebacks into an
// in-order FIFO, drains it on rf_grant and forwards queued values to decode. Option: WBQ_BYPASS_EN.
module wb_write_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [4:0]                 a_rd,
    input  logic [XLEN-1:0]            a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_rd,
    input  logic [XLEN-1:0]            b_data,
    input  logic                       rf_grant,
    output logic                       reg_write,
    output logic [4:0]                 rd,
    output logic [XLEN-1:0]            write_data,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    output logic                       fwd1_hit,
    output logic [XLEN-1:0]            fwd1_data,
    output logic                       fwd2_hit,
    output logic [XLEN-1:0]            fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic            acc_a;
    logic            acc_b;
    logic [4:0]      req_rd;
    logic [XLEN-1:0] req_data;
    logic            req_ok;
    logic            pop;
    logic            push;
    logic            byp;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Single push per cycle; A wins, and a full queue refuses even while draining.
    assign a_ready = !full;
    assign b_ready = !full && !a_valid;
    assign acc_a   = a_valid && a_ready;
    assign acc_b   = b_valid && b_ready;

    assign req_rd   = acc_a ? a_rd   : b_rd;
    assign req_data = acc_a ? a_data : b_data;
    // x0 writes are acknowledged but dropped here so they never occupy a slot.
    assign req_ok   = (acc_a || acc_b) && (req_rd != 5'd0);

    assign pop = !empty && rf_grant;

`ifdef WBQ_BYPASS_EN
    assign byp = empty && rf_grant && req_ok;
`else
    assign byp = 1'b0;
`endif

    assign push       = req_ok && !byp;
    assign reg_write  = pop || byp;
    assign rd         = byp ? req_rd   : q_rd[rd_ptr];
    assign write_data = byp ? req_data : q_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Entry storage needs no reset: occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= req_rd;
            q_data[wr_ptr] <= req_data;
        end
    end

    // Walk oldest to youngest so the last match (youngest) is what remains.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (rs1 != 5'd0 && q_rd[idx] == rs1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = q_data[idx];
                end
                if (rs2 != 5'd0 && q_rd[idx] == rs2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = q_data[idx];
                end
            end
        end
        if (byp && rs1 != 5'd0 && req_rd == rs1) begin
            fwd1_hit  = 1'b1;
            fwd1_data = req_data;
        end
        if (byp && rs2 != 5'd0 && req_rd == rs2) begin
            fwd2_hit  = 1'b1;
            fwd2_data = req_data;
        end
    end

endmodule
